pps_capture: RTL and testbench

- Multi-channel pulse-per-second capture unit for the external timing inputs of the NTP server FPGA.
- Each channel does the following:
  - synchronises an asynchronous PPS pin;
  - rejects edges that arrive too early;
  - timestamps each accepted rising edge with the 64-bit NTP time;
  - counts events;
  - flags missing pulses.
- Results are exposed through the standard 32-bit cs/we register API to the management CPU, and an interrupt line is provided.

---
 rtl/pps_capture_pkg.sv | 31 +++
 rtl/pps_capture_ch.sv | 92 +++++++++
 rtl/pps_capture.sv | 94 +++++++++
 tb/tb_pps_capture.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pps_capture_pkg.sv
// pps_capture_pkg: register map, status bit positions and identity constants
// shared by the PPS capture top level and its per-channel slice.
package pps_capture_pkg;

    localparam logic [7:0] ADDR_NAME0   = 8'h00;
    localparam logic [7:0] ADDR_NAME1   = 8'h01;
    localparam logic [7:0] ADDR_VERSION = 8'h02;
    localparam logic [7:0] ADDR_NUM_CH  = 8'h03;
    localparam logic [7:0] ADDR_IRQ_EN  = 8'h08;

    localparam logic [7:0] CH_BASE   = 8'h10;
    localparam int         CH_STRIDE = 4;

    localparam logic [1:0] OFF_SEC    = 2'd0;
    localparam logic [1:0] OFF_FRAC   = 2'd1;
    localparam logic [1:0] OFF_STATUS = 2'd2;
    localparam logic [1:0] OFF_COUNT  = 2'd3;

    localparam int ST_VALID   = 0;
    localparam int ST_LOST    = 1;
    localparam int ST_OVERRUN = 2;

    localparam logic [31:0] CORE_NAME0   = 32'h7070_735f;
    localparam logic [31:0] CORE_NAME1   = 32'h6361_7074;
    localparam logic [31:0] CORE_VERSION = 32'h302e_3130;

    function automatic logic [7:0] ch_addr(input int ch, input logic [1:0] off);
        return CH_BASE + 8'(ch * CH_STRIDE) + {6'd0, off};
    endfunction

endpackage

// File: rtl/pps_capture_ch.sv
// pps_capture_ch: one PPS channel -- synchroniser, edge detect, gap filter,
// watchdog, atomic 64-bit timestamp capture, sticky flags and event counters.
// Ports:
//   clk, areset      clock, asynchronous active-low reset
//   pps_in           asynchronous PPS pin
//   ntp_time         64-bit NTP time, synchronous to clk
//   clr_status       W1C mask {overrun, lost, valid}
//   clr_cnt          clears event and reject counters
//   cap_sec/cap_frac captured timestamp words
//   status, counts   register images for the API mux
//   valid            capture-valid flag for the interrupt logic
module pps_capture_ch
    import pps_capture_pkg::*;
#(
    parameter int MIN_GAP = 78125000,
    parameter int TIMEOUT = 234375000
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        pps_in,
    input  logic [63:0] ntp_time,
    input  logic [2:0]  clr_status,
    input  logic        clr_cnt,
    output logic [31:0] cap_sec,
    output logic [31:0] cap_frac,
    output logic [31:0] status,
    output logic [31:0] counts,
    output logic        valid
);

    localparam logic [31:0] GAP_MAX = 32'(MIN_GAP);
    localparam logic [31:0] WD_MAX  = 32'(TIMEOUT);

    logic [2:0]  sync_q, sync_d;
    logic [31:0] gap_q, gap_d;
    logic [31:0] wd_q, wd_d;
    logic [63:0] cap_q, cap_d;
    logic        valid_q, valid_d;
    logic        lost_q, lost_d;
    logic        overrun_q, overrun_d;
    logic [15:0] event_q, event_d;
    logic [15:0] reject_q, reject_d;
    logic        rise, accept;

    always_comb begin
        rise      = sync_q[1] & ~sync_q[2];
        accept    = rise & (gap_q == GAP_MAX);
        sync_d    = {sync_q[1:0], pps_in};
        gap_d     = accept ? '0 : (gap_q == GAP_MAX ? gap_q : gap_q + 32'd1);
        wd_d      = accept ? '0 : (wd_q == WD_MAX ? wd_q : wd_q + 32'd1);
        cap_d     = accept ? ntp_time : cap_q;
        // set terms are OR-ed after the W1C mask so a same-cycle set wins
        valid_d   = accept | (valid_q & ~clr_status[ST_VALID]);
        overrun_d = (accept & valid_q) | (overrun_q & ~clr_status[ST_OVERRUN]);
        // lost sets only on the step into TIMEOUT, so a W1C sticks while
        // the watchdog stays saturated
        lost_d    = (~accept & (wd_q == WD_MAX - 32'd1)) | (lost_q & ~clr_status[ST_LOST]);
        event_d   = (clr_cnt ? '0 : event_q) + 16'(accept);
        reject_d  = (clr_cnt ? '0 : reject_q) + 16'(rise & ~accept);
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            sync_q    <= '0;
            gap_q     <= GAP_MAX;
            wd_q      <= '0;
            cap_q     <= '0;
            valid_q   <= 1'b0;
            lost_q    <= 1'b0;
            overrun_q <= 1'b0;
            event_q   <= '0;
            reject_q  <= '0;
        end else begin
            sync_q    <= sync_d;
            gap_q     <= gap_d;
            wd_q      <= wd_d;
            cap_q     <= cap_d;
            valid_q   <= valid_d;
            lost_q    <= lost_d;
            overrun_q <= overrun_d;
            event_q   <= event_d;
            reject_q  <= reject_d;
        end
    end

    assign cap_sec  = cap_q[63:32];
    assign cap_frac = cap_q[31:0];
    assign status   = {29'd0, overrun_q, lost_q, valid_q};
    assign counts   = {reject_q, event_q};
    assign valid    = valid_q;

endmodule

// File: rtl/pps_capture.sv
// pps_capture: multi-channel PPS timestamp unit with 32-bit cs/we register API.
// Ports:
//   clk, areset          clock, asynchronous active-low reset
//   ntp_time             64-bit NTP time (seconds:fraction)
//   pps_in               asynchronous PPS pins, one per channel
//   cs, we, address,
//   write_data           register access; writes land at the clock edge
//   read_data            combinational read data, 0 unless cs & ~we
//   irq                  registered level interrupt, |(valid & irq_en)
module pps_capture
    import pps_capture_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int MIN_GAP = 78125000,
    parameter int TIMEOUT = 234375000
) (
    input  logic              clk,
    input  logic              areset,
    input  logic [63:0]       ntp_time,
    input  logic [NUM_CH-1:0] pps_in,
    input  logic              cs,
    input  logic              we,
    input  logic [7:0]        address,
    input  logic [31:0]       write_data,
    output logic [31:0]       read_data,
    output logic              irq
);

    logic              wr;
    logic [31:0]       ch_word [NUM_CH][4];
    logic [NUM_CH-1:0] valid;
    logic [NUM_CH-1:0] irq_en_q, irq_en_d;
    logic              irq_q, irq_d;
    logic [31:0]       ch_rd, rd;
    logic              unused_wdata;

    assign wr           = cs & we;
    assign unused_wdata = ^write_data[31:3];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [2:0] clr_status;
        logic       clr_cnt;
        assign clr_status = (wr && address == ch_addr(g, OFF_STATUS)) ? write_data[2:0] : 3'd0;
        assign clr_cnt    = wr && address == ch_addr(g, OFF_COUNT);
        pps_capture_ch #(
            .MIN_GAP(MIN_GAP),
            .TIMEOUT(TIMEOUT)
        ) u_ch (
            .clk       (clk),
            .areset    (areset),
            .pps_in    (pps_in[g]),
            .ntp_time  (ntp_time),
            .clr_status(clr_status),
            .clr_cnt   (clr_cnt),
            .cap_sec   (ch_word[g][OFF_SEC]),
            .cap_frac  (ch_word[g][OFF_FRAC]),
            .status    (ch_word[g][OFF_STATUS]),
            .counts    (ch_word[g][OFF_COUNT]),
            .valid     (valid[g])
        );
    end

    always_comb begin
        irq_en_d = (wr && address == ADDR_IRQ_EN) ? write_data[NUM_CH-1:0] : irq_en_q;
        irq_d    = |(valid & irq_en_q);
    end

    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
        end
    end

    // channel windows beyond NUM_CH never match and fall through to 0
    always_comb begin
        ch_rd = '0;
        for (int c = 0; c < NUM_CH; c++)
            if ({address[7:2], 2'b00} == ch_addr(c, OFF_SEC))
                ch_rd = ch_word[c][address[1:0]];
        rd = address == ADDR_NAME0   ? CORE_NAME0 :
             address == ADDR_NAME1   ? CORE_NAME1 :
             address == ADDR_VERSION ? CORE_VERSION :
             address == ADDR_NUM_CH  ? 32'(NUM_CH) :
             address == ADDR_IRQ_EN  ? 32'(irq_en_q) : ch_rd;
    end

    assign read_data = (cs & ~we) ? rd : '0;
    assign irq       = irq_q;

endmodule

// File: tb/tb_pps_capture.sv
// tb_pps_capture: directed, table-driven bench for pps_capture (MIN_GAP=10, TIMEOUT=50).
module tb_pps_capture;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        areset = 1'b0;
    logic [63:0] ntp_time = 64'h0000_0001_0000_0000;
    logic [1:0]  pps_in = 2'b00;
    logic        cs = 1'b0;
    logic        we = 1'b0;
    logic [7:0]  address = 8'h00;
    logic [31:0] write_data = 32'h0;
    logic [31:0] read_data;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;
    vec_t id_vec [16];
    logic [63:0] t0, t12;

    always #5 clk = ~clk;

    pps_capture #(.NUM_CH(2), .MIN_GAP(10), .TIMEOUT(50)) dut (
        .clk(clk), .areset(areset), .ntp_time(ntp_time), .pps_in(pps_in),
        .cs(cs), .we(we), .address(address), .write_data(write_data),
        .read_data(read_data), .irq(irq)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // one clock: the posedge inside sees the current ntp_time
    task automatic step();
        @(negedge clk);
        ntp_time = ntp_time + 64'd1;
    endtask

    task automatic cyc(input int n);
        repeat (n) step();
    endtask

    task automatic rd(input logic [7:0] a, input logic [31:0] exp, input string name);
        cs = 1'b1; we = 1'b0; address = a;
        #1;
        chk(name, {32'd0, read_data}, {32'd0, exp});
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        cs = 1'b1; we = 1'b1; address = a; write_data = d;
        step();
        we = 1'b0; cs = 1'b0;
    endtask

    // pin high before edge N; accepted at edge N+2, which sees ntp(raise)+2
    task automatic pulse(input int ch);
        pps_in[ch] = 1'b1;
        step();
        step();
        pps_in[ch] = 1'b0;
        step();
    endtask

    task automatic reset_dut();
        pps_in = 2'b00; cs = 1'b0; we = 1'b0;
        areset = 1'b0;
        cyc(2);
        areset = 1'b1;
    endtask

    initial begin
        id_vec[0]  = '{8'h00, 32'h7070735f};
        id_vec[1]  = '{8'h01, 32'h63617074};
        id_vec[2]  = '{8'h02, 32'h302e3130};
        id_vec[3]  = '{8'h03, 32'h00000002};
        id_vec[4]  = '{8'h04, 32'h0};
        id_vec[5]  = '{8'h08, 32'h0};
        for (int i = 0; i < 8; i++) id_vec[6 + i] = '{8'(8'h10 + i), 32'h0};
        id_vec[14] = '{8'h18, 32'h0};
        id_vec[15] = '{8'hff, 32'h0};

        // 1. reset / identity
        reset_dut();
        chk("irq_reset", {63'd0, irq}, 64'd0);
        cs = 1'b0; address = 8'h00;
        #1;
        chk("rd_idle", {32'd0, read_data}, 64'd0);
        for (int i = 0; i < 16; i++) begin
            rd(id_vec[i].addr, id_vec[i].exp, $sformatf("id_rd_%02h", id_vec[i].addr));
            step();
        end

        // 2. capture latency
        t0 = ntp_time;
        pulse(0);
        rd(8'h10, t0[63:32] + 32'd0, "cap_sec");
        rd(8'h11, 32'(t0[31:0] + 32'd2), "cap_frac");
        rd(8'h12, 32'h1, "cap_status");
        step();
        rd(8'h13, 32'h1, "cap_counts");
        rd(8'h16, 32'h0, "ch1_status");
        rd(8'h17, 32'h0, "ch1_counts");
        chk("irq_disabled", {63'd0, irq}, 64'd0);

        // 3. gap filter: offsets 5 (reject) and 12 (accept) from edge A
        cyc(1);
        pulse(0);
        cyc(4);
        t12 = ntp_time;
        pulse(0);
        rd(8'h11, 32'(t12[31:0] + 32'd2), "gap_frac");
        rd(8'h13, 32'h0001_0002, "gap_counts");
        rd(8'h12, 32'h5, "gap_status");

        // 4. W1C racing an accepted edge, then quiet clears
        reset_dut();
        pulse(0);
        cyc(12);
        pps_in[0] = 1'b1;
        step();
        step();
        pps_in[0] = 1'b0;
        wr(8'h12, 32'h1);
        rd(8'h12, 32'h5, "w1c_set_wins");
        rd(8'h13, 32'h2, "w1c_counts");
        wr(8'h12, 32'h7);
        rd(8'h12, 32'h0, "w1c_quiet");
        wr(8'h13, 32'h1234);
        rd(8'h13, 32'h0, "cnt_clear");

        // 5. watchdog
        reset_dut();
        pulse(0);
        cyc(49);
        rd(8'h12, 32'h1, "wd_49");
        step();
        rd(8'h12, 32'h3, "wd_50");
        rd(8'h16, 32'h2, "wd_ch1_idle");
        pulse(0);
        rd(8'h12, 32'h7, "wd_sticky");
        wr(8'h12, 32'h2);
        rd(8'h12, 32'h5, "wd_w1c");

        // 6. irq and mid-operation reset
        reset_dut();
        wr(8'h08, 32'h2);
        rd(8'h08, 32'h2, "irq_en_rd");
        pps_in[1] = 1'b1;
        step();
        step();
        step();
        pps_in[1] = 1'b0;
        rd(8'h16, 32'h1, "irq_ch1_valid");
        chk("irq_lat0", {63'd0, irq}, 64'd0);
        step();
        chk("irq_lat1", {63'd0, irq}, 64'd1);
        wr(8'h16, 32'h1);
        step();
        chk("irq_drop", {63'd0, irq}, 64'd0);
        cyc(12);
        pulse(1);
        step();
        chk("irq_again", {63'd0, irq}, 64'd1);
        cyc(12);
        pps_in[1] = 1'b1;
        step();
        areset = 1'b0;
        #1;
        chk("irq_async_rst", {63'd0, irq}, 64'd0);
        pps_in[1] = 1'b0;
        cyc(2);
        areset = 1'b1;
        cyc(4);
        rd(8'h14, 32'h0, "rst_cap_sec");
        rd(8'h16, 32'h0, "rst_status");
        rd(8'h17, 32'h0, "rst_counts");
        step();
        rd(8'h08, 32'h0, "rst_irq_en");
        chk("rst_irq", {63'd0, irq}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
